fetch_buffer_unit: RTL and testbench
====================================

// Module: fetch_buffer_unit
// PURPOSE
// - Parametrised front-end fetch stage; owns the PC and drives the single-port instruction memory.
// - Tracks one outstanding read and discards responses made stale by a redirect.
// - Buffers {pc, instr} pairs in a DEPTH-entry FIFO feeding instruction_decoder via valid/ready.
// - Replaces the fixed-depth program_counter + instruction_fetcher pair.
// PARAMETERS
// - DEPTH     8        fetch FIFO entries; >= 2
// - XLEN      32       PC and instruction width
// - RESET_PC  32'h60   PC loaded on reset
// PORTS
// - clk             in   1     clock, rising edge
// - rst             in   1     reset, asynchronous, active-low
// - flush_i         in   1     pipeline flush: clear FIFO, discard in-flight read
// - load_branch_i   in   1     redirect to branch_pc_i
// - branch_pc_i     in   XLEN  branch target
// - load_jalr_i     in   1     redirect to jalr_pc_i
// - jalr_pc_i       in   XLEN  jalr target (bit 0 cleared internally)
// - mem_read_o      out  1     instruction read request
// - mem_address_o   out  XLEN  read address, 4-byte aligned
// - mem_resp_i      in   1     read complete
// - mem_rdata_i     in   XLEN  read data
// - fetch_vld_o     out  1     FIFO head valid
// - fetch_rdy_i     in   1     decoder accepts head
// - fetch_instr_o   out  XLEN  head instruction
// - fetch_pc_o      out  XLEN  head PC
// - fetch_pred_o    out  1     head was predicted taken
// - pc_o            out  XLEN  next fetch PC
// - count_o         out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
// - Reset (async, rst=0): pc_o=RESET_PC; FIFO empty; count_o=0; fetch_vld_o=0; mem_read_o=0;
//   mem_address_o=RESET_PC; fetch_pred_o=0; FSM=IDLE.
// - FSM states: IDLE, REQ, DRAIN.
//   - IDLE->REQ when count_o < DEPTH and no redirect/flush this cycle; latch mem_address_o=pc_o.
//   - REQ: mem_read_o=1, address held stable. mem_resp_i -> push {addr, rdata}; pc += 4;
//     return to IDLE, or stay in REQ back-to-back if count after push < DEPTH.
//   - REQ + redirect/flush, no same-cycle resp -> DRAIN.
//   - DRAIN: mem_read_o=1, old address held; on mem_resp_i drop data, go IDLE.
//   - REQ + redirect/flush + same-cycle mem_resp_i: data dropped, go IDLE.
// - Reservation: in-flight read counts against capacity; request only if count_o + inflight < DEPTH.
//   A push never overflows.
// - Redirect priority: load_branch_i > load_jalr_i.
//   - The winning target loads pc_o next cycle; the FIFO clears.
//   - flush_i alone clears the FIFO and drops in-flight data; pc_o is unchanged.
// - Push/pop: pop when fetch_vld_o & fetch_rdy_i. Simultaneous push and pop leaves count unchanged.
// - Full: no new request is issued. Empty: fetch_vld_o=0 and head fields hold their last value.
// - Redirect, flush, push and pop in the same cycle: the clear wins; the FIFO is empty next cycle.
// - Latency: a response at edge N is visible at the head at N+1 when the FIFO was empty.
//   Redirect at edge N -> first request to the new target at N+1 (or after DRAIN).
// - Arithmetic: PC is +4 modulo 2^XLEN and wraps silently. Pointers wrap modulo DEPTH;
//   DEPTH need not be a power of 2.
// CONFIGURATION
// - STATIC_BRANCH_PREDICT_EN defined:
//   - On push, a B-type word (opcode 7'b1100011) with negative b_imm sets the next PC to addr+b_imm,
//     not +4; the entry is pushed with fetch_pred_o=1.
//   - A redirect in the same cycle still wins.
// - Undefined: always +4; fetch_pred_o tied 0.
// TESTING
// - Reset, memory with 1-cycle resp, rdy=1 -> addresses 0x60, 0x64, 0x68...;
//   fetch_pc_o tracks these with 1-cycle lag.
// - fetch_rdy_i=0, DEPTH=8 -> exactly 8 reads; count_o=8; mem_read_o=0 until a pop.
// - load_branch_i=1 (0x200) and load_jalr_i=1 (0x301) in the same cycle, REQ pending 3 cycles ->
//   DRAIN drops old data; next address is 0x200; FIFO empty.
// - flush_i coincident with mem_resp_i and a pop -> count_o=0 next cycle; no push; pc_o unchanged.
// - Macro on: word 0xFE000EE3 (beq, -4) at 0x80 -> fetch_pred_o=1; next address 0x7C.
//   Macro off -> next address 0x84.
// - pc_o=0xFFFFFFFC fetch -> next address 0x00000000.

Source files
------------

// File: rtl/fetch_buffer_unit.sv
// Front-end fetch: owns the PC, keeps one instruction read outstanding, queues {pc, instr} for decode.
// Build option STATIC_BRANCH_PREDICT_EN: backward B-type branches are predicted taken when pushed.
module fetch_buffer_unit #(
  parameter int              DEPTH    = 8,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h60
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       load_branch_i,
  input  logic [XLEN-1:0]            branch_pc_i,
  input  logic                       load_jalr_i,
  input  logic [XLEN-1:0]            jalr_pc_i,
  output logic                       mem_read_o,
  output logic [XLEN-1:0]            mem_address_o,
  input  logic                       mem_resp_i,
  input  logic [XLEN-1:0]            mem_rdata_i,
  output logic                       fetch_vld_o,
  input  logic                       fetch_rdy_i,
  output logic [XLEN-1:0]            fetch_instr_o,
  output logic [XLEN-1:0]            fetch_pc_o,
  output logic                       fetch_pred_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;
  state_t r_state, w_nstate;

  logic            w_redir, w_clr, w_push, w_pop, w_issue, w_chain, w_pred_tkn;
  logic [XLEN-1:0] r_pc, r_addr, w_tgt, w_pc_nxt, w_bimm;
  logic [CW-1:0]   r_count, w_count_pp;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;

  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic            r_fifo_pred  [DEPTH];
  logic [XLEN-1:0] r_last_pc, r_last_instr;
  logic            r_last_pred;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Branch beats jalr; any clear source drops the queue and the in-flight data.
  assign w_redir = load_branch_i | load_jalr_i;
  assign w_clr   = w_redir | flush_i;
  assign w_tgt   = load_branch_i ? branch_pc_i : (jalr_pc_i & ~XLEN'(1));

  assign w_push     = (r_state == REQ) & mem_resp_i & ~w_clr;
  assign w_pop      = fetch_vld_o & fetch_rdy_i;
  assign w_count_pp = r_count + CW'(w_push) - CW'(w_pop);

`ifdef STATIC_BRANCH_PREDICT_EN
  assign w_bimm     = {{(XLEN-12){mem_rdata_i[31]}}, mem_rdata_i[7], mem_rdata_i[30:25],
                       mem_rdata_i[11:8], 1'b0};
  assign w_pred_tkn = (mem_rdata_i[6:0] == 7'b1100011) & mem_rdata_i[31];
`else
  assign w_bimm     = '0;
  assign w_pred_tkn = 1'b0;
`endif

  assign w_pc_nxt = w_pred_tkn ? (r_addr + w_bimm) : (r_addr + XLEN'(4));

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nstate;
  end

  // FSM: next state. The in-flight read reserves a slot, so REQ only chains while room remains.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:  if (!w_clr && (r_count < DEPTH_C)) w_nstate = REQ;
      REQ: begin
        if (w_clr)           w_nstate = mem_resp_i ? IDLE : DRAIN;
        else if (mem_resp_i) w_nstate = (w_count_pp < DEPTH_C) ? REQ : IDLE;
      end
      DRAIN: if (mem_resp_i) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_read_o = 1'b0;
    if (r_state == REQ || r_state == DRAIN) mem_read_o = 1'b1;
  end

  assign w_issue = (r_state == IDLE) & (w_nstate == REQ);
  assign w_chain = w_push & (w_nstate == REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      if (w_redir)     r_pc <= w_tgt;
      else if (w_push) r_pc <= w_pc_nxt;
      if (w_issue)      r_addr <= align4(r_pc);
      else if (w_chain) r_addr <= align4(w_pc_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_pp;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_addr;
      r_fifo_instr[r_wr_ptr] <= mem_rdata_i;
      r_fifo_pred[r_wr_ptr]  <= w_pred_tkn;
    end
  end

  // Remember the last shown head so the fields hold steady while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_pc    <= '0;
      r_last_instr <= '0;
      r_last_pred  <= 1'b0;
    end else if (fetch_vld_o) begin
      r_last_pc    <= r_fifo_pc[r_rd_ptr];
      r_last_instr <= r_fifo_instr[r_rd_ptr];
      r_last_pred  <= r_fifo_pred[r_rd_ptr];
    end
  end

  assign fetch_vld_o   = (r_count != '0);
  assign fetch_pc_o    = fetch_vld_o ? r_fifo_pc[r_rd_ptr]    : r_last_pc;
  assign fetch_instr_o = fetch_vld_o ? r_fifo_instr[r_rd_ptr] : r_last_instr;
  assign fetch_pred_o  = fetch_vld_o ? r_fifo_pred[r_rd_ptr]  : r_last_pred;
  assign count_o       = r_count;
  assign pc_o          = r_pc;
  assign mem_address_o = r_addr;

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Bench for fetch_buffer_unit: queue-based fetch-stream model, random memory latency and redirects.
module tb_fetch_buffer_unit;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
`ifdef STATIC_BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic            clk = 1'b0, rst = 1'b0;
  logic            flush_i = 0, load_branch_i = 0, load_jalr_i = 0;
  logic [XLEN-1:0] branch_pc_i = '0, jalr_pc_i = '0;
  logic            mem_read_o, mem_resp_i = 0;
  logic [XLEN-1:0] mem_address_o, mem_rdata_i = '0;
  logic            fetch_vld_o, fetch_rdy_i = 0, fetch_pred_o;
  logic [XLEN-1:0] fetch_instr_o, fetch_pc_o, pc_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  fetch_buffer_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h60)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .load_branch_i(load_branch_i), .branch_pc_i(branch_pc_i),
    .load_jalr_i(load_jalr_i), .jalr_pc_i(jalr_pc_i),
    .mem_read_o(mem_read_o), .mem_address_o(mem_address_o),
    .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
    .fetch_vld_o(fetch_vld_o), .fetch_rdy_i(fetch_rdy_i),
    .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o), .fetch_pred_o(fetch_pred_o),
    .pc_o(pc_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  typedef struct {logic [31:0] pc; logic [31:0] ins; bit pred;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h60, m_stale_addr = '0, last_push = '0;
  bit          m_stale = 0, lat_rand = 0;
  int          wcnt = 0, lat = 0, n_push = 0, n_drop = 0;

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h80) return 32'hFE000EE3;
    return ((a * 32'h9E3779B1) & ~32'h7F) | 32'h13;
  endfunction

  function automatic logic [31:0] bimm(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // One clock: serve memory, let the edge happen, advance the model, compare.
  task automatic step();
    logic rd, rs, clr, redir, pop;
    logic [31:0] addr, tgt, w;
    ent_t e;
    mem_resp_i  = mem_read_o && (wcnt >= lat);
    mem_rdata_i = word(mem_address_o);
    rd = mem_read_o; rs = mem_resp_i; addr = mem_address_o; w = mem_rdata_i;
    redir = load_branch_i | load_jalr_i;
    clr   = redir | flush_i;
    tgt   = load_branch_i ? branch_pc_i : (jalr_pc_i & ~32'h1);
    pop   = fetch_vld_o && fetch_rdy_i;
    @(posedge clk); #1;
    if (rd && rs) begin wcnt = 0; if (lat_rand) lat = $urandom_range(0, 3); end
    else if (rd) wcnt++;
    else wcnt = 0;
    if (clr) begin
      mq.delete();
      if (rd && rs) begin n_drop++; m_stale = 0; end
      else if (rd && !m_stale) begin m_stale = 1; m_stale_addr = al(m_pc); end
      if (redir) m_pc = tgt;
    end else begin
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (rd && rs) begin
        if (m_stale) begin n_drop++; m_stale = 0; end
        else begin
          chk("rsp_addr", addr, al(m_pc));
          e.pc = al(m_pc); e.ins = w;
          e.pred = PRED && (w[6:0] == 7'b1100011) && w[31];
          mq.push_back(e);
          m_pc = e.pred ? e.pc + bimm(w) : e.pc + 32'd4;
          last_push = e.pc; n_push++;
        end
      end
    end
    chk("count", count_o, mq.size());
    chk("vld", fetch_vld_o, mq.size() != 0);
    chk("pc", pc_o, m_pc);
    if (mq.size() > 0) begin
      chk("head_pc", fetch_pc_o, mq[0].pc);
      chk("head_ins", fetch_instr_o, mq[0].ins);
      chk("head_pred", fetch_pred_o, mq[0].pred);
    end
    if (mem_read_o) chk("req_addr", mem_address_o, m_stale ? m_stale_addr : al(m_pc));
    if (m_stale) chk("drain_rd", mem_read_o, 1);
    if (mq.size() == DEPTH && !m_stale) chk("full_rd", mem_read_o, 0);
  endtask

  task automatic redirect_branch(input logic [31:0] t);
    load_branch_i = 1; branch_pc_i = t;
    step();
    load_branch_i = 0;
  endtask

  task automatic wait_push(input logic [31:0] a, input string tag);
    int p0 = n_push;
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = (n_push > p0) && (last_push == a);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0, r;
    logic [31:0] pcb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 32'h60);
    chk("rst_cnt", count_o, 0);
    chk("rst_vld", fetch_vld_o, 0);
    chk("rst_rd", mem_read_o, 0);
    chk("rst_addr", mem_address_o, 32'h60);
    chk("rst_pred", fetch_pred_o, 0);
    rst = 1;

    // Sequential fetch, 1-cycle memory, decoder always ready
    fetch_rdy_i = 1; lat = 0;
    step(); chk("seq_req0", mem_address_o, 32'h60);
    step(); chk("seq_head0", fetch_pc_o, 32'h60);
    step(); chk("seq_head1", fetch_pc_o, 32'h64);
    repeat (6) step();

    // Fill: decoder stalled
    fetch_rdy_i = 0; lat_rand = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin step(); ok = (count_o == DEPTH); end
    chk("full_cnt", count_o, DEPTH);
    repeat (4) begin step(); chk("full_noreq", mem_read_o, 0); end

    // Branch + jalr together while a read has been pending 3 cycles
    lat_rand = 0; lat = 1000; fetch_rdy_i = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = mem_read_o; end
    chk("redir_req_tmo", ok, 1);
    repeat (3) step();
    load_jalr_i = 1; jalr_pc_i = 32'h301;
    redirect_branch(32'h200);
    load_jalr_i = 0;
    chk("redir_cnt", count_o, 0);
    chk("redir_pc", pc_o, 32'h200);
    chk("redir_drain", mem_read_o, 1);
    lat = 2; d0 = n_drop; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = (n_drop != d0); end
    chk("drain_tmo", ok, 1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = mem_read_o; end
    chk("redir_addr", mem_address_o, 32'h200);

    // Flush coincident with a response and a pop
    lat = 0;
    repeat (6) step();
    chk("flush_pre", {mem_read_o, fetch_vld_o}, 2'b11);
    pcb = m_pc;
    flush_i = 1; step(); flush_i = 0;
    chk("flush_cnt", count_o, 0);
    chk("flush_vld", fetch_vld_o, 0);
    chk("flush_pc", pc_o, pcb);

    // Backward beq at 0x80
    redirect_branch(32'h80);
    wait_push(32'h80, "pred_tmo");
    chk("pred_addr", mem_address_o, PRED ? 32'h7C : 32'h84);
    chk("pred_head", fetch_pc_o, 32'h80);
    chk("pred_flag", fetch_pred_o, PRED);

    // PC wrap
    redirect_branch(32'hFFFF_FFFC);
    wait_push(32'hFFFF_FFFC, "wrap_tmo");
    chk("wrap_addr", mem_address_o, 32'h0);
    chk("wrap_pc", pc_o, 32'h0);

    // Random traffic
    lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      fetch_rdy_i = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      load_branch_i = (r < 2) || (r == 4);
      load_jalr_i   = (r >= 2 && r < 5);
      flush_i       = ($urandom_range(0, 99) < 3);
      branch_pc_i   = $urandom & 32'h0000_0FFC;
      jalr_pc_i     = $urandom & 32'h0000_0FFF;
      step();
    end
    load_branch_i = 0; load_jalr_i = 0; flush_i = 0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
